debug_clock_controller: RTL
===========================

DEBUG_CLOCK_CONTROLLER -- requirements
Module: debug_clock_controller

Interface
REQ-001 Parameter HALF_PERIOD, default 25'd24999999, CLK_IN cycles per CPU_CLK half-period minus one.
REQ-002 CLK_IN  input  1  sole clock; all state updates on posedge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 RUN  input  1  level; free-running CPU_CLK while high.
REQ-005 STEP  input  1  one-cycle pulse; request exactly one CPU_CLK period.
REQ-006 BURST_START  input  1  one-cycle pulse; request BURST_LEN CPU_CLK periods.
REQ-007 BURST_LEN  input  8  burst period count, sampled only on the accepted BURST_START cycle.
REQ-008 CPU_CLK  output  1  gated, divided debug clock to the CPU; registered.
REQ-009 TICK  output  1  one-cycle pulse, high in the same cycle CPU_CLK first reads 1 after a rising toggle.
REQ-010 BUSY  output  1  high whenever state is not IDLE.
REQ-011 DONE  output  1  one-cycle pulse on every return to IDLE from an active state.
REQ-012 EDGE_CNT  output  16  total CPU_CLK rising edges since reset.

Function
REQ-013 States SHALL be IDLE, RUN, STEP, BURST and DRAIN.
REQ-014 In IDLE, CPU_CLK SHALL be 0 and the half-period counter SHALL hold.
REQ-015 In IDLE, simultaneous requests SHALL be prioritised BURST_START > STEP > RUN; the lower-priority requests are ignored that cycle.
REQ-016 STEP or BURST_START arriving outside IDLE SHALL be ignored with no effect.
REQ-017 On acceptance, the counter SHALL load HALF_PERIOD.
REQ-018 In any active state, a counter at 0 SHALL toggle CPU_CLK and reload HALF_PERIOD; otherwise it decrements by 1.
REQ-019 Consequence of REQ-017/018: first rising edge HALF_PERIOD+1 cycles after acceptance; full period 2*(HALF_PERIOD+1) cycles.
REQ-020 RUN state SHALL toggle continuously while RUN=1.
REQ-021 RUN falling while CPU_CLK=0 SHALL return the block to IDLE next cycle, discarding the counter value.
REQ-022 RUN falling while CPU_CLK=1 SHALL enter DRAIN, which completes the falling toggle on schedule and then returns to IDLE.
REQ-023 STEP state SHALL produce one rising and one falling toggle, then return to IDLE.
REQ-024 BURST state SHALL produce exactly BURST_LEN rising and falling pairs, counted by an 8-bit remaining-count register, then return to IDLE.
REQ-025 BURST_LEN=0 SHALL be accepted, enter no active toggling, and pulse DONE in the next cycle.
REQ-026 Every return to IDLE SHALL coincide with CPU_CLK=0, and DONE SHALL pulse in that transition cycle.
REQ-027 RUN going high during STEP or BURST SHALL be ignored until IDLE; if RUN is still high in IDLE, RUN starts per REQ-015.
REQ-028 EDGE_CNT SHALL increment with each TICK and wrap from 16'hFFFF to 0.

Reset
REQ-029 RESET=1 at a clock edge SHALL force IDLE, CPU_CLK=0, TICK=0, BUSY=0, DONE=0, EDGE_CNT=0, counter=0 and remaining count=0, including mid-burst and mid-high-phase.
REQ-030 RESET SHALL take priority over all requests, and no DONE pulse SHALL result from reset.
REQ-031 No initial blocks SHALL be relied upon for functional reset values.

Structure
REQ-032 State encodings (3-bit localparams) and the HALF_PERIOD default SHALL live in a shared debug-clock definitions package/include.
REQ-033 The down-counter with reload and zero-detect SHALL be a sub-module, clk_phase_timer (inputs: load, enable; output: expire), instantiated once.
REQ-034 The FSM, CPU_CLK register, burst counter and EDGE_CNT SHALL reside in debug_clock_controller.

Verification (HALF_PERIOD=3 unless noted)
REQ-035 STEP pulse in IDLE -> CPU_CLK rises 4 cycles later with TICK=1, falls 4 cycles after that with DONE=1 the same cycle, BUSY high throughout, EDGE_CNT=1.
REQ-036 BURST_START with BURST_LEN=3 -> exactly 3 TICKs spaced 8 cycles apart, DONE 28 cycles after acceptance, EDGE_CNT=3; BURST_LEN=0 -> DONE the next cycle, no TICK.
REQ-037 RUN held for 30 cycles, dropped with CPU_CLK=1 -> DRAIN, falling edge on schedule, then IDLE with DONE; dropped with CPU_CLK=0 -> IDLE next cycle.
REQ-038 STEP, BURST_START and RUN asserted in the same IDLE cycle -> burst executes, and the STEP is lost.
REQ-039 RESET asserted mid-burst with CPU_CLK=1 -> next cycle CPU_CLK=0, BUSY=0, EDGE_CNT=0, no DONE.
REQ-040 EDGE_CNT preloaded via 65535 STEPs (HALF_PERIOD=0) -> next TICK wraps EDGE_CNT to 0.

Source files
------------

// File: rtl/debug_clock_controller_pkg.sv
// Shared definitions for the debug clock controller: state encodings,
// half-period counter width and the default half-period reload value.
package debug_clock_controller_pkg;

    localparam int HP_W = 25;
    localparam logic [HP_W-1:0] HALF_PERIOD_DEFAULT = 25'd24999999;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_BURST = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_STEP  = ST_STEP,
        S_BURST = ST_BURST,
        S_DRAIN = ST_DRAIN
    } state_t;

endpackage

// File: rtl/debug_clock_controller_timer.sv
// Half-period down-counter: load presets HALF_PERIOD, enable counts down and
// reloads at zero; expire flags the zero count while enabled.
module clk_phase_timer
    import debug_clock_controller_pkg::*;
#(
    parameter logic [HP_W-1:0] HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    logic [HP_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= HALF_PERIOD;
        end else if (enable) begin
            if (count == '0) begin
                count <= HALF_PERIOD;
            end else begin
                count <= count - HP_W'(1);
            end
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/debug_clock_controller.sv
// Debug clock controller: gates and divides CLK_IN into CPU_CLK for free-run,
// single-step and counted-burst operation, with tick/done/edge-count reporting.
module debug_clock_controller
    import debug_clock_controller_pkg::*;
#(
    parameter logic [HP_W-1:0] HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic        CLK_IN,
    input  logic        RESET,
    input  logic        RUN,
    input  logic        STEP,
    input  logic        BURST_START,
    input  logic [7:0]  BURST_LEN,
    output logic        CPU_CLK,
    output logic        TICK,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] EDGE_CNT
);

    state_t     state;
    logic [7:0] remaining;
    logic       load;
    logic       enable;
    logic       expire;

    assign load   = (state == S_IDLE) && (BURST_START || STEP || RUN);
    assign enable = (state != S_IDLE);
    assign BUSY   = (state != S_IDLE);

    clk_phase_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clk   (CLK_IN),
        .reset (RESET),
        .load  (load),
        .enable(enable),
        .expire(expire)
    );

    // A burst checks its remaining count at the expiry that would start the
    // next high phase, so the last low phase runs a full half-period before
    // DONE. A zero-length burst goes straight through DRAIN with CPU_CLK low.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state     <= S_IDLE;
            CPU_CLK   <= 1'b0;
            TICK      <= 1'b0;
            DONE      <= 1'b0;
            EDGE_CNT  <= '0;
            remaining <= '0;
        end else begin
            TICK <= 1'b0;
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    CPU_CLK <= 1'b0;
                    if (BURST_START) begin
                        remaining <= BURST_LEN;
                        state     <= (BURST_LEN == 8'd0) ? S_DRAIN : S_BURST;
                    end else if (STEP) begin
                        state <= S_STEP;
                    end else if (RUN) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!RUN && !CPU_CLK) begin
                        state <= S_IDLE;
                        DONE  <= 1'b1;
                    end else if (expire) begin
                        CPU_CLK <= !CPU_CLK;
                        if (!CPU_CLK) begin
                            TICK     <= 1'b1;
                            EDGE_CNT <= EDGE_CNT + 16'd1;
                        end else if (!RUN) begin
                            state <= S_IDLE;
                            DONE  <= 1'b1;
                        end
                    end else if (!RUN) begin
                        state <= S_DRAIN;
                    end
                end
                S_STEP: begin
                    if (expire) begin
                        if (!CPU_CLK) begin
                            CPU_CLK  <= 1'b1;
                            TICK     <= 1'b1;
                            EDGE_CNT <= EDGE_CNT + 16'd1;
                        end else begin
                            CPU_CLK <= 1'b0;
                            state   <= S_IDLE;
                            DONE    <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (expire) begin
                        if (CPU_CLK) begin
                            CPU_CLK <= 1'b0;
                        end else if (remaining == 8'd0) begin
                            state <= S_IDLE;
                            DONE  <= 1'b1;
                        end else begin
                            CPU_CLK   <= 1'b1;
                            TICK      <= 1'b1;
                            EDGE_CNT  <= EDGE_CNT + 16'd1;
                            remaining <= remaining - 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!CPU_CLK) begin
                        state <= S_IDLE;
                        DONE  <= 1'b1;
                    end else if (expire) begin
                        CPU_CLK <= 1'b0;
                        state   <= S_IDLE;
                        DONE    <= 1'b1;
                    end
                end
                default: begin
                    CPU_CLK <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
